pmp_cfg_regs: RTL and testbench

- M-mode CSR-side storage and write-legalisation for the PMP entries and mseccfg (Smepmp).
- It is the writer/owner end of the PMP configuration interface: it drives the `conf_addr`, `conf` and `mconf` bundles consumed by every PMP checker instance.
- It sits behind the CSR file and applies lock, WARL and sticky-bit rules on each write.
- Outputs are registered, so checkers see a new configuration one cycle after the CSR write.

---
 rtl/pmp_cfg_regs.sv | 209 ++++++++++++++++++++
 tb/tb_pmp_cfg_regs.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_cfg_regs.sv
// PMP configuration CSR storage with lock, WARL and sticky-bit write legalisation.
// Smepmp support (mseccfg storage and MML-dependent rules) is enabled by defining CVA6_PMP_SMEPMP_EN.

package riscv;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } mseccfg_t;

endpackage

module pmp_cfg_regs #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          csr_we_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [XLEN-1:0]               csr_wdata_i,
    output logic [XLEN-1:0]               csr_rdata_o,
    output logic [15:0][PMP_LEN-1:0]      conf_addr_o,
    output riscv::pmpcfg_t [15:0]         conf_o,
    output riscv::mseccfg_t               mconf_o,
    output logic                          cfg_changed_o,
    output logic                          wr_dropped_o
);

    localparam int unsigned NB          = XLEN / 8;
    localparam bit          RV32        = (XLEN == 32);
    localparam logic [16:0] IMPL_ONEHOT = 17'd1 << NR_ENTRIES;
    localparam logic [15:0] IMPL_MASK   = 16'(IMPL_ONEHOT - 17'd1);

    riscv::pmpcfg_t [15:0]      conf_q, conf_d;
    logic [15:0][PMP_LEN-1:0]   addr_q, addr_d;
    logic                       changed_q, dropped_q;
    logic                       changed, dropped;

    logic                       is_cfg, is_addr, is_msec;
    logic [3:0]                 cfg_base, addr_idx, addr_next_idx;
    logic [15:0]                locked_vec, tor_vec;
    logic                       any_locked, addr_blocked;
    logic                       mml, rlb;
    logic [3:0]                 e;
    riscv::pmpcfg_t             new_byte;

`ifdef CVA6_PMP_SMEPMP_EN
    localparam logic [11:0]     ADDR_MSECCFG = 12'h747;
    riscv::mseccfg_t            msec_q, msec_d;

    assign mml     = msec_q.mml;
    assign rlb     = msec_q.rlb;
    assign is_msec = (csr_addr_i == ADDR_MSECCFG);
    assign mconf_o = msec_q;
`else
    assign mml     = 1'b0;
    assign rlb     = 1'b0;
    assign is_msec = 1'b0;
    assign mconf_o = '0;
`endif

    // RV64 only exposes the even pmpcfg CSRs; each CSR byte maps to one entry.
    assign is_cfg        = (csr_addr_i[11:2] == 10'h0E8) && (RV32 || !csr_addr_i[0]);
    assign is_addr       = (csr_addr_i[11:4] == 8'h3B);
    assign cfg_base      = {csr_addr_i[1:0], 2'b00};
    assign addr_idx      = csr_addr_i[3:0];
    assign addr_next_idx = addr_idx + 4'd1;

    always_comb begin
        locked_vec = '0;
        tor_vec    = '0;
        for (int i = 0; i < 16; i++) begin
            locked_vec[i] = conf_q[i].locked;
            tor_vec[i]    = (conf_q[i].addr_mode == riscv::TOR);
        end
    end

    assign any_locked = |(locked_vec & IMPL_MASK);

    // A locked TOR entry also freezes the pmpaddr below it, since that is its base.
    assign addr_blocked = !rlb && (locked_vec[addr_idx] ||
                          ((addr_idx != 4'd15) && locked_vec[addr_next_idx] && tor_vec[addr_next_idx]));

    always_comb begin
        conf_d   = conf_q;
        addr_d   = addr_q;
        dropped  = 1'b0;
        e        = '0;
        new_byte = '0;
`ifdef CVA6_PMP_SMEPMP_EN
        msec_d   = msec_q;
`endif
        if (csr_we_i && is_cfg) begin
            for (int j = 0; j < NB; j++) begin
                e                 = cfg_base + 4'(j);
                new_byte          = riscv::pmpcfg_t'(csr_wdata_i[8*j +: 8]);
                new_byte.reserved = 2'b00;
                if (IMPL_MASK[e]) begin
                    if (locked_vec[e] && !rlb) begin
                        dropped = 1'b1;
                    end else if (!mml && !new_byte.access_type.r && new_byte.access_type.w) begin
                        dropped = 1'b1;
                    end else if (mml && !rlb && new_byte.locked &&
                                 ((!new_byte.access_type.r && new_byte.access_type.w) ||
                                  (new_byte.access_type.x && (new_byte.access_type != 3'b111)))) begin
                        dropped = 1'b1;
                    end else begin
                        conf_d[e] = new_byte;
                    end
                end
            end
        end else if (csr_we_i && is_addr && IMPL_MASK[addr_idx]) begin
            if (addr_blocked) begin
                dropped = 1'b1;
            end else begin
                addr_d[addr_idx] = PMP_LEN'(csr_wdata_i);
            end
        end
`ifdef CVA6_PMP_SMEPMP_EN
        else if (csr_we_i && is_msec) begin
            msec_d.mml  = msec_q.mml  | csr_wdata_i[0];
            msec_d.mmwp = msec_q.mmwp | csr_wdata_i[1];
            if (!csr_wdata_i[2]) begin
                msec_d.rlb = 1'b0;
            end else if (msec_q.rlb || !any_locked) begin
                msec_d.rlb = 1'b1;
            end else begin
                dropped = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        changed = (conf_d != conf_q) || (addr_d != addr_q);
`ifdef CVA6_PMP_SMEPMP_EN
        changed = changed || (msec_d != msec_q);
`endif
    end

    always_comb begin
        csr_rdata_o = '0;
        if (is_cfg) begin
            for (int j = 0; j < NB; j++) begin
                csr_rdata_o[8*j +: 8] = conf_q[cfg_base + 4'(j)];
            end
        end else if (is_addr) begin
            csr_rdata_o = XLEN'(addr_q[addr_idx]);
        end
`ifdef CVA6_PMP_SMEPMP_EN
        else if (is_msec) begin
            csr_rdata_o[2:0] = msec_q;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conf_q    <= '0;
            addr_q    <= '0;
            changed_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            conf_q    <= conf_d;
            addr_q    <= addr_d;
            changed_q <= changed;
            dropped_q <= dropped;
        end
    end

`ifdef CVA6_PMP_SMEPMP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msec_q <= '0;
        end else begin
            msec_q <= msec_d;
        end
    end
`endif

    assign conf_o        = conf_q;
    assign conf_addr_o   = addr_q;
    assign cfg_changed_o = changed_q;
    assign wr_dropped_o  = dropped_q;

endmodule

// File: tb/tb_pmp_cfg_regs.sv
// Randomized self-checking bench for pmp_cfg_regs against an entry-level CSR model.
// Built with 12 implemented entries so the unimplemented-entry boundary is reachable.

module tb_pmp_cfg_regs;

    localparam int NRE = 12;

    logic                   clk_i = 1'b0;
    logic                   rst_n;
    logic                   csr_we;
    logic [11:0]            csr_addr;
    logic [63:0]            csr_wdata;
    logic [63:0]            csr_rdata;
    logic [15:0][53:0]      conf_addr;
    riscv::pmpcfg_t [15:0]  conf;
    riscv::mseccfg_t        mconf;
    logic                   changed;
    logic                   dropped;

    int test_count = 0;
    int fail_count = 0;

    logic [7:0]  mcfg  [16];
    logic [53:0] maddr [16];
    logic        m_mml, m_mmwp, m_rlb;

    pmp_cfg_regs #(.XLEN(64), .PMP_LEN(54), .NR_ENTRIES(NRE)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_n),
        .csr_we_i      (csr_we),
        .csr_addr_i    (csr_addr),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .conf_addr_o   (conf_addr),
        .conf_o        (conf),
        .mconf_o       (mconf),
        .cfg_changed_o (changed),
        .wr_dropped_o  (dropped)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            mcfg[i]  = 8'h00;
            maddr[i] = '0;
        end
        m_mml  = 1'b0;
        m_mmwp = 1'b0;
        m_rlb  = 1'b0;
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a);
        logic [63:0] r;
        int base;
        r = '0;
        if (a == 12'h3A0 || a == 12'h3A2) begin
            base = (a == 12'h3A2) ? 8 : 0;
            for (int j = 0; j < 8; j++) r[8*j +: 8] = mcfg[base + j];
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            r = {10'b0, maddr[int'(a - 12'h3B0)]};
        end
`ifdef CVA6_PMP_SMEPMP_EN
        else if (a == 12'h747) begin
            r = {61'b0, m_rlb, m_mmwp, m_mml};
        end
`endif
        return r;
    endfunction

    // Applies one CSR write to the model; all rules are judged on the pre-write state.
    function automatic void model_write(input logic [11:0] a, input logic [63:0] d,
                                        output logic chg, output logic drp);
        logic [7:0]  old_cfg  [16];
        logic [53:0] old_addr [16];
        logic [2:0]  old_sec;
        logic [7:0]  b;
        logic        r, w, x, l, any_lock;
        int          base, e, i;
        old_cfg  = mcfg;
        old_addr = maddr;
        old_sec  = {m_rlb, m_mmwp, m_mml};
        drp      = 1'b0;
        any_lock = 1'b0;
        for (int k = 0; k < NRE; k++) if (old_cfg[k][7]) any_lock = 1'b1;
        if (a == 12'h3A0 || a == 12'h3A2) begin
            base = (a == 12'h3A2) ? 8 : 0;
            for (int j = 0; j < 8; j++) begin
                e = base + j;
                b = d[8*j +: 8] & 8'h9F;
                r = b[0]; w = b[1]; x = b[2]; l = b[7];
                if (e < NRE) begin
                    if (old_cfg[e][7] && !m_rlb) drp = 1'b1;
                    else if (!m_mml && !r && w) drp = 1'b1;
                    else if (m_mml && !m_rlb && l && ((!r && w) || (x && b[2:0] != 3'b111))) drp = 1'b1;
                    else mcfg[e] = b;
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            i = int'(a - 12'h3B0);
            if (i < NRE) begin
                if (!m_rlb && (old_cfg[i][7] ||
                    (i < 15 && old_cfg[i+1][7] && old_cfg[i+1][4:3] == 2'b01))) drp = 1'b1;
                else maddr[i] = d[53:0];
            end
        end
`ifdef CVA6_PMP_SMEPMP_EN
        else if (a == 12'h747) begin
            m_mml  = m_mml | d[0];
            m_mmwp = m_mmwp | d[1];
            if (!d[2]) m_rlb = 1'b0;
            else if (m_rlb || !any_lock) m_rlb = 1'b1;
            else drp = 1'b1;
        end
`endif
        chg = (old_sec != {m_rlb, m_mmwp, m_mml});
        for (int k = 0; k < 16; k++) if (old_cfg[k] != mcfg[k] || old_addr[k] != maddr[k]) chg = 1'b1;
    endfunction

    task automatic check_state();
        logic [127:0] exp_conf;
        for (int i = 0; i < 16; i++) exp_conf[8*i +: 8] = mcfg[i];
        checkOutput("conf_o", conf, exp_conf);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("conf_addr_o[%0d]", i), conf_addr[i], maddr[i]);
        checkOutput("mconf_o", mconf, {m_rlb, m_mmwp, m_mml});
    endtask

    task automatic applyStimulus(input logic [11:0] a, input logic [63:0] d);
        logic exp_chg, exp_drp;
        @(negedge clk_i);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        #1;
        checkOutput($sformatf("rdata_old@%0h", a), csr_rdata, model_read(a));
        @(posedge clk_i);
        model_write(a, d, exp_chg, exp_drp);
        #1;
        csr_we = 1'b0;
        checkOutput($sformatf("cfg_changed@%0h", a), changed, exp_chg);
        checkOutput($sformatf("wr_dropped@%0h", a), dropped, exp_drp);
        check_state();
    endtask

    task automatic check_read(input string tag, input logic [11:0] a, input logic [63:0] exp);
        @(negedge clk_i);
        csr_we   = 1'b0;
        csr_addr = a;
        #1;
        checkOutput(tag, csr_rdata, exp);
    endtask

    task automatic idle_cycle();
        @(posedge clk_i);
        #1;
        checkOutput("changed_idle", changed, 1'b0);
        checkOutput("dropped_idle", dropped, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n  = 1'b0;
        csr_we = 1'b0;
        #2;
        checkOutput("rst_changed", changed, 1'b0);
        checkOutput("rst_dropped", dropped, 1'b0);
        checkOutput("rst_conf", conf, 128'b0);
        checkOutput("rst_mconf", mconf, 3'b0);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("rst_addr%0d", i), conf_addr[i], 54'b0);
        model_reset();
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    task automatic random_op();
        int sel;
        logic [11:0] a;
        logic [63:0] d;
        sel = $urandom_range(0, 99);
        d   = {$urandom, $urandom};
        if (sel < 30) begin
            a = 12'h3A0 + 12'($urandom_range(0, 3));
            for (int j = 0; j < 8; j++) d[8*j + 7] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) d = model_read(a);
        end else if (sel < 70) begin
            a = 12'h3B0 + 12'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) d = model_read(a);
        end else if (sel < 77) begin
            a = 12'h747;
            d = 64'($urandom_range(0, 7));
        end else if (sel < 85) begin
            case ($urandom_range(0, 3))
                0:       a = 12'h3A4;
                1:       a = 12'h3C0;
                2:       a = 12'h746;
                default: a = 12'h300;
            endcase
        end else begin
            a = 12'h3A0 + 12'($urandom_range(0, 31));
            check_read("rand_read", a, model_read(a));
            return;
        end
        applyStimulus(a, d);
    endtask

    initial begin
        rst_n     = 1'b0;
        csr_we    = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;
        model_reset();

        do_reset();
        for (int i = 0; i < 4; i++) check_read("reset_pmpcfg", 12'h3A0 + 12'(i), 64'h0);
        for (int i = 0; i < 16; i++) check_read("reset_pmpaddr", 12'h3B0 + 12'(i), 64'h0);
        check_read("reset_mseccfg", 12'h747, 64'h0);
        idle_cycle();

        // Locked entry cannot be cleared without RLB
        do_reset();
        applyStimulus(12'h3A0, 64'h8F);
        checkOutput("lock_first_chg", changed, 1'b1);
        checkOutput("lock_first_drp", dropped, 1'b0);
        applyStimulus(12'h3A0, 64'h0);
        checkOutput("lock_second_chg", changed, 1'b0);
        checkOutput("lock_second_drp", dropped, 1'b1);
        check_read("lock_entry0", 12'h3A0, 64'h8F);
        idle_cycle();

        // Locked TOR entry1 freezes pmpaddr0 but not pmpaddr2
        do_reset();
        applyStimulus(12'h3A0, 64'h8900);
        applyStimulus(12'h3B0, 64'h1000);
        checkOutput("tor_addr0_drp", dropped, 1'b1);
        checkOutput("tor_addr0_chg", changed, 1'b0);
        check_read("tor_addr0", 12'h3B0, 64'h0);
        applyStimulus(12'h3B2, 64'h2000);
        checkOutput("tor_addr2_chg", changed, 1'b1);
        checkOutput("tor_addr2_drp", dropped, 1'b0);
        check_read("tor_addr2", 12'h3B2, 64'h2000);

        // R=0,W=1 keeps the previous byte while MML=0
        do_reset();
        applyStimulus(12'h3A0, 64'h0B00_0000);
        applyStimulus(12'h3A0, 64'h0A00_0000);
        checkOutput("rw01_chg", changed, 1'b0);
        check_read("rw01_entry3", 12'h3A0, 64'h0B00_0000);

        // Unimplemented entries, upper address bits and unknown CSRs
        do_reset();
        applyStimulus(12'h3A2, 64'h0F0F_0F0F_0F0F_0F0F);
        checkOutput("bound_cfg_drp", dropped, 1'b0);
        check_read("bound_cfg", 12'h3A2, 64'h0000_0000_0F0F_0F0F);
        applyStimulus(12'h3BC, 64'h55);
        checkOutput("bound_addr_chg", changed, 1'b0);
        checkOutput("bound_addr_drp", dropped, 1'b0);
        check_read("bound_addr12", 12'h3BC, 64'h0);
        applyStimulus(12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF);
        check_read("addr_upper", 12'h3B3, 64'h003F_FFFF_FFFF_FFFF);
        applyStimulus(12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("odd_cfg_chg", changed, 1'b0);
        checkOutput("odd_cfg_drp", dropped, 1'b0);
        check_read("odd_cfg", 12'h3A1, 64'h0);

`ifdef CVA6_PMP_SMEPMP_EN
        do_reset();
        applyStimulus(12'h747, 64'h7);
        check_read("msec_set", 12'h747, 64'h7);
        applyStimulus(12'h747, 64'h0);
        check_read("msec_sticky", 12'h747, 64'h3);
        applyStimulus(12'h3A0, 64'h89);
        checkOutput("mml_lock_chg", changed, 1'b1);
        applyStimulus(12'h747, 64'h4);
        checkOutput("rlb_reject_drp", dropped, 1'b1);
        check_read("rlb_reject", 12'h747, 64'h3);

        do_reset();
        applyStimulus(12'h747, 64'h4);
        applyStimulus(12'h3A0, 64'h8F);
        applyStimulus(12'h3A0, 64'h0);
        checkOutput("rlb_unlock_drp", dropped, 1'b0);
        check_read("rlb_unlock", 12'h3A0, 64'h0);

        do_reset();
        applyStimulus(12'h747, 64'h1);
        applyStimulus(12'h3A0, 64'h8C);
        checkOutput("mml_x_drp", dropped, 1'b1);
        check_read("mml_x", 12'h3A0, 64'h0);
        applyStimulus(12'h3A0, 64'h89);
        checkOutput("mml_r_drp", dropped, 1'b0);
        check_read("mml_r", 12'h3A0, 64'h89);
`else
        do_reset();
        applyStimulus(12'h747, 64'h7);
        checkOutput("msec_absent_chg", changed, 1'b0);
        checkOutput("msec_absent_drp", dropped, 1'b0);
        check_read("msec_absent", 12'h747, 64'h0);
`endif

        // Reset asserted across a pmpaddr write edge loses the write
        do_reset();
        applyStimulus(12'h3B5, 64'hABC);
        @(negedge clk_i);
        csr_we    = 1'b1;
        csr_addr  = 12'h3B5;
        csr_wdata = 64'h1234;
        #2;
        rst_n = 1'b0;
        @(posedge clk_i);
        #1;
        csr_we = 1'b0;
        checkOutput("rstw_addr5", conf_addr[5], 54'h0);
        model_reset();
        @(negedge clk_i);
        rst_n = 1'b1;
        check_read("rstw_read", 12'h3B5, 64'h0);
        idle_cycle();

        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            repeat (150) random_op();
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
